// File: rtl/apb_matmul_master_pkg.sv
// Shared types and default widths for the matmul APB initiator and target.
package matmul_apb_pkg;

  localparam int APB_BUS_WIDTH      = 64;
  localparam int APB_ADDR_WIDTH     = 32;
  localparam int APB_STRB_WIDTH     = APB_BUS_WIDTH / 8;
  localparam int APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

  // Request/response held at the widest supported widths; the top slices them.
  typedef struct packed {
    logic                      write;
    logic                      wait_idle;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_BUS_WIDTH-1:0]  wdata;
    logic [APB_STRB_WIDTH-1:0] strb;
  } apb_req_t;

  typedef struct packed {
    logic [APB_BUS_WIDTH-1:0] rdata;
    logic                     err;
    logic                     timeout;
  } apb_rsp_t;

  // APB4: reads never carry byte strobes.
  function automatic logic [APB_STRB_WIDTH-1:0] apb4_strb(apb_req_t r);
    return r.write ? r.strb : '0;
  endfunction

endpackage

// File: rtl/apb_matmul_master_if.sv
// Request/response channels, APB bus and busy input of the matmul APB initiator.
interface apb_matmul_master_if #(
  parameter int BUS_WIDTH  = matmul_apb_pkg::APB_BUS_WIDTH,
  parameter int ADDR_WIDTH = matmul_apb_pkg::APB_ADDR_WIDTH,
  parameter int STRB_WIDTH = BUS_WIDTH / 8
) ();
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic                  req_wait_idle_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [BUS_WIDTH-1:0]  req_wdata_i;
  logic [STRB_WIDTH-1:0] req_strb_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [BUS_WIDTH-1:0]  rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;

  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [BUS_WIDTH-1:0]  pwdata_o;
  logic [STRB_WIDTH-1:0] pstrb_o;
  logic                  pready_i;
  logic                  pslverr_i;
  logic [BUS_WIDTH-1:0]  prdata_i;

  logic                  busy_i;

  // The initiator block itself.
  modport master (
    input  req_valid_i, req_write_i, req_wait_idle_i, req_addr_i, req_wdata_i, req_strb_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    input  pready_i, pslverr_i, prdata_i,
    input  busy_i
  );

  // Everything around it: sequencer, response consumer and APB target.
  modport slave (
    output req_valid_i, req_write_i, req_wait_idle_i, req_addr_i, req_wdata_i, req_strb_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    output pready_i, pslverr_i, prdata_i,
    output busy_i
  );
endinterface

// File: rtl/apb_matmul_master_timeout_cnt.sv
// ACCESS-phase watchdog: counts wait states, flags when TIMEOUT_CYCLES is reached.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES));

  // Clear wins; saturate at the limit so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/apb_matmul_master.sv
// APB initiator for the matmul accelerator: one SETUP/ACCESS transfer per
// request, optional hold until the accelerator is idle.
// Optional watchdog on the ACCESS phase: define APB_TIMEOUT_EN.
module apb_matmul_master
  import matmul_apb_pkg::*;
#(
  parameter int BUS_WIDTH      = APB_BUS_WIDTH,
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int STRB_WIDTH     = BUS_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  apb_matmul_master_if.master  bus
);

  apb_state_e state_q, state_d;
  apb_req_t   req_q, req_d;
  apb_rsp_t   rsp_q, rsp_d;
  logic       rdy_en_q;
  logic       tmo_abort;
  logic [APB_STRB_WIDTH-1:0] strb_gated;

`ifdef APB_TIMEOUT_EN
  logic tmo_expired;

  apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (state_q == ST_SETUP),
    .en_i      ((state_q == ST_ACCESS) && !bus.pready_i),
    .expired_o (tmo_expired)
  );

  // A late pready on the limit cycle still completes the transfer.
  assign tmo_abort = tmo_expired && !bus.pready_i;
`else
  wire unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
  assign tmo_abort = 1'b0;
`endif

  // State, captured request and registered response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      rsp_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rsp_q    <= rsp_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Next state, request capture and response capture.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i && rdy_en_q) begin
          req_d.write     = bus.req_write_i;
          req_d.wait_idle = bus.req_wait_idle_i;
          req_d.addr      = APB_ADDR_WIDTH'(bus.req_addr_i);
          req_d.wdata     = APB_BUS_WIDTH'(bus.req_wdata_i);
          req_d.strb      = APB_STRB_WIDTH'(bus.req_strb_i);
          state_d = (bus.req_wait_idle_i && bus.busy_i) ? ST_WAIT_IDLE : ST_SETUP;
        end
      end
      ST_WAIT_IDLE: if (!bus.busy_i) state_d = ST_SETUP;
      ST_SETUP:     state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.pready_i) begin
          rsp_d.rdata   = req_q.write ? '0 : APB_BUS_WIDTH'(bus.prdata_i);
          rsp_d.err     = bus.pslverr_i;
          rsp_d.timeout = 1'b0;
          state_d       = ST_RESP;
        end else if (tmo_abort) begin
          rsp_d.rdata   = '0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP:  if (bus.rsp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign strb_gated = apb4_strb(req_q);

  // Ready is held low until the first clock after reset release.
  assign bus.req_ready_o   = rdy_en_q && (state_q == ST_IDLE);
  assign bus.psel_o        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign bus.penable_o     = (state_q == ST_ACCESS);
  assign bus.pwrite_o      = req_q.write;
  assign bus.paddr_o       = req_q.addr[ADDR_WIDTH-1:0];
  assign bus.pwdata_o      = req_q.write ? req_q.wdata[BUS_WIDTH-1:0] : '0;
  assign bus.pstrb_o       = strb_gated[STRB_WIDTH-1:0];
  assign bus.rsp_valid_o   = (state_q == ST_RESP);
  assign bus.rsp_rdata_o   = rsp_q.rdata[BUS_WIDTH-1:0];
  assign bus.rsp_err_o     = rsp_q.err;
  assign bus.rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_apb_matmul_master.sv
// Self-checking bench for apb_matmul_master: transaction model with timing
// computed from latency arithmetic, per-cycle compare, random + directed traffic.
module tb_apb_matmul_master;
  localparam int TMO = 16;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  apb_matmul_master_if bus ();

  apb_matmul_master #(
    .BUS_WIDTH(64), .ADDR_WIDTH(32), .STRB_WIDTH(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Expected transaction: b = busy-hold cycles, w = ACCESS wait states seen.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [7:0]  strb;
    int          b;
    int          w;
    logic [63:0] rd;
    logic        err;
    logic        to;
  } exp_t;

  exp_t q[$];
  bit   mon_en = 1'b0;

  int          tgt_waits = 0;
  logic        tgt_err = 1'b0;
  logic [63:0] tgt_rdata = '0;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, a, e, cyc);
    end
  endtask

  // Transaction-level reference.
  function automatic exp_t model(input logic wr, wi, input logic [31:0] addr,
                                 input logic [63:0] wd, input logic [7:0] strb,
                                 input int nb, w, input logic err, input logic [63:0] prd);
    exp_t e;
    bit abort;
    abort  = TO_EN && (w > TMO);
    e.wr   = wr;
    e.addr = addr;
    e.wd   = wd;
    e.strb = strb;
    e.b    = wi ? nb : 0;
    e.w    = abort ? TMO : w;
    e.rd   = (abort || wr) ? 64'h0 : prd;
    e.err  = abort ? 1'b1 : err;
    e.to   = abort;
    return e;
  endfunction

  // Target: ready after tgt_waits ACCESS cycles; garbage on data while waiting.
  initial begin
    int n;
    n = 0;
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b0;
    bus.prdata_i  = '0;
    forever begin
      @(posedge clk_i); #1;
      if (bus.psel_o && bus.penable_o) begin
        bus.pready_i  = (n == tgt_waits);
        bus.prdata_i  = (n == tgt_waits) ? tgt_rdata : {$urandom, $urandom};
        bus.pslverr_i = (n == tgt_waits) ? tgt_err : 1'($urandom);
        n++;
      end else begin
        n = 0;
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model. Cycle index rel counts intervals after
  // the accepting edge: 0..b-1 held for busy, b SETUP, then w+1 ACCESS, then RESP.
  initial begin
    exp_t cur;
    bit   act;
    int   t0, rel;
    act = 1'b0;
    t0  = 0;
    forever begin
      @(negedge clk_i);
      if (!mon_en) begin
        act = 1'b0;
        q.delete();
      end else begin
        if (act) begin
          rel = cyc - t0;
          if (rel < cur.b)
            chk("hold_busy", {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.req_ready_o}, 4'b0000);
          else if (rel == cur.b)
            chk("setup", {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o, bus.pstrb_o},
                {3'b100, cur.wr, cur.addr, cur.wr ? cur.wd : 64'h0, cur.wr ? cur.strb : 8'h0});
          else if (rel <= cur.b + 1 + cur.w)
            chk("access", {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o, bus.pstrb_o},
                {3'b110, cur.wr, cur.addr, cur.wr ? cur.wd : 64'h0, cur.wr ? cur.strb : 8'h0});
          else begin
            chk("resp", {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.req_ready_o, bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o},
                {4'b0010, cur.rd, cur.err, cur.to});
            if (bus.rsp_ready_i) act = 1'b0;
          end
        end else begin
          chk("idle", {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.req_ready_o}, 4'b0001);
        end
        if (!act && bus.req_valid_i && bus.req_ready_o) begin
          if (q.size() == 0) begin
            chk("unexpected_accept", 1, 0);
          end else begin
            cur = q.pop_front();
            act = 1'b1;
            t0  = cyc + 1;
          end
        end
      end
    end
  end

  // One request start to finish; returns latencies (in cycles after acceptance)
  // and the response fields seen on the first RESP cycle.
  task automatic do_txn(input logic wr, wi, input logic [31:0] addr, input logic [63:0] wd,
                        input logic [7:0] strb, input int nb, w, input logic err,
                        input logic [63:0] prd, input int stall,
                        output int lat_setup, lat_rsp, output logic [63:0] g_rd,
                        output logic g_err, g_to, output logic [7:0] strb_or);
    int n, st, acc;
    bit hs;
    tgt_waits = w;
    tgt_err   = err;
    tgt_rdata = prd;
    lat_setup = -1; lat_rsp = -1; g_rd = '0; g_err = 1'b0; g_to = 1'b0; strb_or = '0;
    n = 0;
    while (!bus.req_ready_o && n < 50) begin
      @(posedge clk_i); #1; n++;
    end
    if (!bus.req_ready_o) begin
      chk("req_ready_timeout", 0, 1);
      return;
    end
    q.push_back(model(wr, wi, addr, wd, strb, nb, w, err, prd));
    bus.req_valid_i     = 1'b1;
    bus.req_write_i     = wr;
    bus.req_wait_idle_i = wi;
    bus.req_addr_i      = addr;
    bus.req_wdata_i     = wd;
    bus.req_strb_i      = strb;
    bus.busy_i          = wi ? (nb > 0) : 1'($urandom);
    @(posedge clk_i); #1;
    acc = cyc;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = {$urandom, $urandom};
    bus.req_strb_i  = 8'($urandom);
    n = 0; st = 0; hs = 1'b0;
    while (n < 300) begin
      if (bus.psel_o) begin
        if (lat_setup < 0) lat_setup = cyc - acc;
        strb_or |= bus.pstrb_o;
      end
      if (hs) begin
        bus.rsp_ready_i = 1'b0;
        break;
      end
      if (bus.rsp_valid_o) begin
        if (lat_rsp < 0) begin
          lat_rsp = cyc - acc;
          g_rd = bus.rsp_rdata_o; g_err = bus.rsp_err_o; g_to = bus.rsp_timeout_o;
        end
        if (st >= stall) begin
          bus.rsp_ready_i = 1'b1;
          hs = 1'b1;
        end else st++;
      end
      bus.busy_i = wi ? (cyc < acc + nb - 1) : 1'($urandom);
      @(posedge clk_i); #1; n++;
    end
    if (!hs) chk("rsp_timeout_wait", 0, 1);
  endtask

  initial begin
    int ls, lr, n;
    logic [63:0] rd;
    logic e, t;
    logic [7:0] so;

    bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_wait_idle_i = 1'b0;
    bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_strb_i = '0;
    bus.rsp_ready_i = 1'b0; bus.busy_i = 1'b0;

    // Reset state: every output low, ready low until the first clock after release.
    #12;
    chk("reset_outs", {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o,
                       bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pstrb_o}, 0);
    chk("reset_pwdata", bus.pwdata_o, 0);
    @(negedge clk_i); #1;
    rst_ni = 1'b1;
    #1 chk("ready_before_clk", bus.req_ready_o, 0);
    @(posedge clk_i); #1;
    chk("ready_after_release", bus.req_ready_o, 1);
    mon_en = 1'b1;

    // Zero-wait write: SETUP right after acceptance, RESP two cycles later.
    do_txn(1'b1, 1'b0, 32'h10, 64'h1122334455667788, 8'hFF, 0, 0, 1'b0, 64'h0, 0, ls, lr, rd, e, t, so);
    chk("wr_setup_lat", ls, 0);
    chk("wr_rsp_lat", lr, 2);
    chk("wr_rdata", rd, 0);
    chk("wr_err", e, 0);
    chk("wr_strb", so, 8'hFF);

    // Read with 3 wait states: strobes stay 0, response 3 cycles later.
    do_txn(1'b0, 1'b0, 32'h20, 64'hAAAA, 8'hF0, 0, 3, 1'b0, 64'hDEADBEEF, 2, ls, lr, rd, e, t, so);
    chk("rd_rsp_lat", lr, 5);
    chk("rd_rdata", rd, 64'hDEADBEEF);
    chk("rd_strb_zero", so, 0);

    // Write answered with pslverr.
    do_txn(1'b1, 1'b0, 32'h30, 64'h5, 8'h0F, 0, 1, 1'b1, 64'h0, 0, ls, lr, rd, e, t, so);
    chk("slverr_err", e, 1);
    chk("slverr_to", t, 0);

    // Wait-for-idle with busy high for 5 cycles.
    do_txn(1'b0, 1'b1, 32'h40, 64'h0, 8'h00, 5, 0, 1'b0, 64'h1234, 0, ls, lr, rd, e, t, so);
    chk("wi_setup_lat", ls, 5);
    chk("wi_rsp_lat", lr, 7);
    chk("wi_rdata", rd, 64'h1234);

`ifdef APB_TIMEOUT_EN
    // Target never ready: aborted after TMO wait cycles.
    do_txn(1'b0, 1'b0, 32'h50, 64'h0, 8'h00, 0, 1000, 1'b0, 64'h77, 0, ls, lr, rd, e, t, so);
    chk("tmo_rsp_lat", lr, 2 + TMO);
    chk("tmo_flags", {e, t}, 2'b11);
    chk("tmo_rdata", rd, 0);
    // Ready on the limit cycle itself completes normally.
    do_txn(1'b0, 1'b0, 32'h54, 64'h0, 8'h00, 0, TMO, 1'b0, 64'h99, 0, ls, lr, rd, e, t, so);
    chk("tmo_edge_flags", {e, t}, 2'b00);
    chk("tmo_edge_rdata", rd, 64'h99);
`endif

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      int w;
      w = (TO_EN && ($urandom % 5 == 0)) ? (TMO - 2 + int'($urandom % 5)) : int'($urandom % 5);
      do_txn(1'($urandom), 1'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom),
             int'($urandom % 5), w, ($urandom % 4 == 0), {$urandom, $urandom}, int'($urandom % 4),
             ls, lr, rd, e, t, so);
    end

    // Asynchronous reset in the middle of ACCESS.
    mon_en = 1'b0;
    tgt_waits = 10;
    bus.req_valid_i = 1'b1; bus.req_write_i = 1'b1; bus.req_wait_idle_i = 1'b0;
    bus.req_addr_i = 32'h60; bus.req_wdata_i = 64'h1; bus.req_strb_i = 8'h1; bus.busy_i = 1'b0;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    n = 0;
    while (!bus.penable_o && n < 20) begin
      @(posedge clk_i); #1; n++;
    end
    chk("reached_access", bus.penable_o, 1);
    #2 rst_ni = 1'b0;
    #1 chk("rst_async_outs", {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.req_ready_o, bus.paddr_o, bus.pstrb_o}, 0);
    #2 rst_ni = 1'b1;
    #1 chk("rst_ready_low", bus.req_ready_o, 0);
    @(posedge clk_i); #1;
    chk("rst_ready_high", {bus.req_ready_o, bus.psel_o}, 2'b10);
    mon_en = 1'b1;

    do_txn(1'b0, 1'b0, 32'h70, 64'h0, 8'h00, 0, 0, 1'b0, 64'hCAFE, 0, ls, lr, rd, e, t, so);
    chk("post_rst_rdata", rd, 64'hCAFE);
    chk("post_rst_lat", lr, 2);

    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound on the run.
  initial begin
    #1000000;
    $display("FAIL global_watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_matmul_master.md
# apb_matmul_master

APB initiator that drives the matrix-multiply accelerator's APB target port. It accepts single-beat read/write requests on a valid/ready request channel, runs one APB SETUP→ACCESS transfer per request, and returns read data and error status on a valid/ready response channel. An optional per-request gate holds the transfer until the accelerator's `busy_o` deasserts. The block sits between the host/test sequencer and the matmul target.

## Interface
- `BUS_WIDTH`, 64: APB data width (16/32/64).
- `ADDR_WIDTH`, 32: APB address width (16/24/32).
- `STRB_WIDTH`, `BUS_WIDTH/8`: byte-strobe width.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS-phase wait states; used only with `APB_TIMEOUT_EN`.
- `clk_i` in 1: the single clock for the block.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: a request is present.
- `req_ready_o` out 1: the block can accept a request.
- `req_write_i` in 1: 1 = write, 0 = read.
- `req_wait_idle_i` in 1: hold the transfer until `busy_i` = 0.
- `req_addr_i` in `ADDR_WIDTH`: target address.
- `req_wdata_i` in `BUS_WIDTH`: write data.
- `req_strb_i` in `STRB_WIDTH`: write byte strobes.
- `rsp_valid_o` out 1: a response is present.
- `rsp_ready_i` in 1: the consumer accepts the response.
- `rsp_rdata_o` out `BUS_WIDTH`: read data; 0 for writes.
- `rsp_err_o` out 1: the target returned `pslverr`, or the transfer timed out.
- `rsp_timeout_o` out 1: the transfer was aborted by the watchdog.
- `psel_o`, `penable_o`, `pwrite_o` out 1: APB control.
- `paddr_o` out `ADDR_WIDTH`, `pwdata_o` out `BUS_WIDTH`, `pstrb_o` out `STRB_WIDTH`: APB address, write data and strobes.
- `pready_i`, `pslverr_i` in 1: APB target handshake and error.
- `prdata_i` in `BUS_WIDTH`: APB read data.
- `busy_i` in 1: accelerator `busy_o`.

## Operation
- FSM states: IDLE, WAIT_IDLE, SETUP, ACCESS, RESP.
- IDLE
  - `req_ready_o` = 1.
  - On `req_valid_i`: register the address, data, strobe, write flag and wait flag.
  - Go to WAIT_IDLE if the wait flag is set and `busy_i` = 1; otherwise go to SETUP.
- WAIT_IDLE
  - Stay while `busy_i` = 1. No APB activity.
  - Go to SETUP on the first cycle `busy_i` = 0.
- SETUP
  - `psel_o` = 1, `penable_o` = 0.
  - Address and control are driven from the registered request.
  - Always go to ACCESS.
- ACCESS
  - `psel_o` = 1, `penable_o` = 1. All APB outputs hold stable.
  - On `pready_i` = 1: capture `prdata_i` (reads only; writes capture 0) and `pslverr_i`, then go to RESP.
- RESP
  - `rsp_valid_o` = 1; `psel_o` = `penable_o` = 0.
  - Hold until `rsp_ready_i`, then return to IDLE.
- Outstanding requests: exactly one; no pipelining.
- `pstrb_o` is forced to 0 on reads (APB4 rule).
- `pwdata_o` is don't-care on reads and is driven 0.
- Reset (asynchronous, may occur mid-transfer):
  - FSM returns to IDLE and all outputs go to 0 immediately, including `psel_o`.
  - `req_ready_o` is 0 while `rst_ni` = 0 and 1 from the first clock after release.

## Timing
- Request accepted at edge T (`req_valid_i` & `req_ready_o`).
  - SETUP during cycle T+1.
  - ACCESS from T+2.
  - A zero-wait target completes at T+2 with `rsp_valid_o` at T+3.
  - Each wait state adds 1 cycle.
- WAIT_IDLE adds one cycle per cycle of `busy_i` = 1 observed.
- Back-to-back throughput: at best 4 cycles per request (IDLE, SETUP, ACCESS, RESP).
- Response outputs are registered and stable while `rsp_valid_o` = 1 and `rsp_ready_i` = 0.

## Configuration
- Macro: `APB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with `pready_i` = 0.
  - When the count reaches `TIMEOUT_CYCLES` with `pready_i` still 0, the transfer is aborted: next state RESP, `psel_o`/`penable_o` drop, `rsp_err_o` = 1, `rsp_timeout_o` = 1, `rsp_rdata_o` = 0.
  - If `pready_i` = 1 on the same cycle the count reaches `TIMEOUT_CYCLES`, the transfer completes normally.
- Undefined: ACCESS waits indefinitely; the `rsp_timeout_o` port remains present and is tied to 0.

## Structure
- Package `matmul_apb_pkg`:
  - FSM state enum.
  - Request struct (write flag, wait flag, address, data, strobe).
  - Response struct (rdata, err, timeout).
  - Default-width localparams shared with the matmul target.
- Sub-module `apb_timeout_cnt`: counter with clear/enable/expired outputs, instantiated only under `APB_TIMEOUT_EN`.

## Test plan
- Write 0x1122334455667788 to 0x10, strb 0xFF, zero-wait target → SETUP at T+1, ACCESS at T+2, `rsp_valid_o` at T+3 with `rsp_err_o` = 0 and `rsp_rdata_o` = 0.
- Read from 0x20, target inserts 3 wait states, returns 0xDEADBEEF → `pstrb_o` = 0 throughout; `rsp_rdata_o` = 0xDEADBEEF at T+6.
- Write with `pslverr_i` = 1 at completion → `rsp_err_o` = 1, `rsp_timeout_o` = 0.
- `req_wait_idle_i` = 1 with `busy_i` high for 5 cycles → `psel_o` stays 0 for those 5 cycles, then SETUP on the first idle cycle.
- With `APB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, target never asserts `pready_i` → abort after 16 ACCESS wait cycles; `rsp_err_o` = 1, `rsp_timeout_o` = 1, `psel_o` = 0.
- Assert `rst_ni` low during ACCESS → `psel_o`/`penable_o`/`rsp_valid_o` go to 0 with no clock edge; `req_ready_o` = 1 one cycle after release.
